// File: rtl/ibex_pkg.sv
// Shared constants and types for the RVC encoder/packer.
// The c.lw/c.sw path is enabled by defining IBEX_RVC_ENCODE_LOADSTORE_EN.
package ibex_pkg;

    typedef enum logic {
        PACK_EMPTY = 1'b0,
        PACK_HALF  = 1'b1
    } pack_state_e;

    localparam logic [6:0] OPCODE_LOAD   = 7'h03;
    localparam logic [6:0] OPCODE_OP_IMM = 7'h13;
    localparam logic [6:0] OPCODE_STORE  = 7'h23;
    localparam logic [6:0] OPCODE_OP     = 7'h33;
    localparam logic [6:0] OPCODE_JALR   = 7'h67;
    localparam logic [6:0] OPCODE_SYSTEM = 7'h73;

    localparam logic [31:0] INSTR_EBREAK = {12'h001, 13'h0, OPCODE_SYSTEM};
    localparam logic [15:0] C_NOP        = 16'h0001;
    localparam logic [15:0] C_EBREAK     = 16'h9002;

endpackage

// File: rtl/ibex_compressed_encode_lut.sv
// Combinational RV32I -> RVC mapping; first matching rule wins.
// c.lw/c.sw are only produced when IBEX_RVC_ENCODE_LOADSTORE_EN is defined.
module ibex_compressed_encode_lut
    import ibex_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [15:0] instr_c_o,
    output logic        is_comp_o
);

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm_i;
    logic        imm_fits6;
    logic        is_jalr0;
    logic        is_add;
    logic        is_addi;
    logic        is_slli;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign funct7 = instr_i[31:25];
    assign imm_i  = instr_i[31:20];

    // 6-bit signed immediate: bits [11:5] must all replicate the sign
    assign imm_fits6 = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7f);

    assign is_jalr0 = (opcode == OPCODE_JALR) && (funct3 == 3'b000) &&
                      (imm_i == 12'h000) && (rs1 != 5'd0);
    assign is_add   = (opcode == OPCODE_OP) && (funct3 == 3'b000) &&
                      (funct7 == 7'h00) && (rd != 5'd0) && (rs2 != 5'd0);
    assign is_addi  = (opcode == OPCODE_OP_IMM) && (funct3 == 3'b000) &&
                      (rd != 5'd0) && imm_fits6;
    assign is_slli  = (opcode == OPCODE_OP_IMM) && (funct3 == 3'b001) &&
                      (funct7 == 7'h00) && (rd != 5'd0) && (rs1 == rd) && (rs2 != 5'd0);

`ifdef IBEX_RVC_ENCODE_LOADSTORE_EN
    logic [11:0] imm_s;
    logic        is_clw;
    logic        is_csw;

    assign imm_s  = {instr_i[31:25], instr_i[11:7]};
    // x8..x15 only, word-aligned offset in [0,124]
    assign is_clw = (opcode == OPCODE_LOAD) && (funct3 == 3'b010) &&
                    (rd[4:3] == 2'b01) && (rs1[4:3] == 2'b01) &&
                    (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'b00);
    assign is_csw = (opcode == OPCODE_STORE) && (funct3 == 3'b010) &&
                    (rs2[4:3] == 2'b01) && (rs1[4:3] == 2'b01) &&
                    (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'b00);
`endif

    always_comb begin
        instr_c_o = 16'h0000;
        is_comp_o = 1'b1;
        if (instr_i[1:0] != 2'b11) begin
            instr_c_o = instr_i[15:0];
        end else if (instr_i == INSTR_EBREAK) begin
            instr_c_o = C_EBREAK;
        end else if (is_jalr0 && (rd == 5'd0)) begin
            instr_c_o = {4'b1000, rs1, 5'd0, 2'b10};
        end else if (is_jalr0 && (rd == 5'd1)) begin
            instr_c_o = {4'b1001, rs1, 5'd0, 2'b10};
        end else if (is_add && (rs1 == 5'd0)) begin
            instr_c_o = {4'b1000, rd, rs2, 2'b10};
        end else if (is_add && (rs1 == rd)) begin
            instr_c_o = {4'b1001, rd, rs2, 2'b10};
        end else if (is_addi && (rs1 == 5'd0)) begin
            instr_c_o = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
        end else if (is_addi && (rs1 == rd) && (imm_i != 12'h000)) begin
            instr_c_o = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
        end else if (is_slli) begin
            instr_c_o = {3'b000, 1'b0, rd, rs2, 2'b10};
`ifdef IBEX_RVC_ENCODE_LOADSTORE_EN
        end else if (is_clw) begin
            instr_c_o = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
        end else if (is_csw) begin
            instr_c_o = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
`endif
        end else begin
            is_comp_o = 1'b0;
        end
    end

endmodule

// File: rtl/ibex_compressed_encoder.sv
// Encodes RV32I instructions to RVC where possible and packs halfwords into 32-bit words.
// Define IBEX_RVC_ENCODE_LOADSTORE_EN to also compress lw/sw (handled in the LUT).
module ibex_compressed_encoder
    import ibex_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic [31:0] instr_i,
    output logic        ready_o,
    input  logic        flush_i,
    output logic        word_valid_o,
    output logic [31:0] word_o,
    input  logic        word_ready_i,
    output logic        half_pending_o,
    output logic [15:0] compressed_cnt_o
);

    pack_state_e state_q, state_d;
    logic [15:0] pending_q, pending_d;
    logic [31:0] word_q, word_d;
    logic        word_valid_q, word_valid_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] instr_c;
    logic        is_comp;
    logic        xfer;

    ibex_compressed_encode_lut u_lut (
        .instr_i   (instr_i),
        .instr_c_o (instr_c),
        .is_comp_o (is_comp)
    );

    assign ready_o = !word_valid_q || word_ready_i;
    assign xfer    = valid_i && ready_o;

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        word_d       = word_q;
        word_valid_d = word_valid_q && !word_ready_i;
        cnt_d        = cnt_q;
        if (xfer) begin
            if (is_comp && (cnt_q != 16'hFFFF)) begin
                cnt_d = cnt_q + 16'd1;
            end
            case (state_q)
                PACK_EMPTY: begin
                    if (is_comp) begin
                        pending_d = instr_c;
                        state_d   = PACK_HALF;
                    end else begin
                        word_d       = instr_i;
                        word_valid_d = 1'b1;
                    end
                end
                PACK_HALF: begin
                    word_valid_d = 1'b1;
                    if (is_comp) begin
                        word_d    = {instr_c, pending_q};
                        pending_d = 16'h0000;
                        state_d   = PACK_EMPTY;
                    end else begin
                        // upper half of the 32-bit form becomes the new pending halfword
                        word_d    = {instr_i[15:0], pending_q};
                        pending_d = instr_i[31:16];
                    end
                end
            endcase
        end else if (flush_i && ready_o && (state_q == PACK_HALF)) begin
            word_d       = {C_NOP, pending_q};
            word_valid_d = 1'b1;
            pending_d    = 16'h0000;
            state_d      = PACK_EMPTY;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= PACK_EMPTY;
            pending_q    <= 16'h0000;
            word_q       <= 32'h0000_0000;
            word_valid_q <= 1'b0;
            cnt_q        <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign word_valid_o     = word_valid_q;
    assign word_o           = word_q;
    assign half_pending_o   = (state_q == PACK_HALF);
    assign compressed_cnt_o = cnt_q;

endmodule

// File: tb/tb_ibex_compressed_encoder.sv
// Bench for ibex_compressed_encoder: directed scenarios plus a randomized run
// against a halfword-stream reference model.
module tb_ibex_compressed_encoder;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic [31:0] instr_i = 32'h0;
    logic        flush_i = 1'b0;
    logic        word_ready_i = 1'b0;
    logic        ready_o;
    logic        word_valid_o;
    logic [31:0] word_o;
    logic        half_pending_o;
    logic [15:0] compressed_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    ibex_compressed_encoder dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .valid_i          (valid_i),
        .instr_i          (instr_i),
        .ready_o          (ready_o),
        .flush_i          (flush_i),
        .word_valid_o     (word_valid_o),
        .word_o           (word_o),
        .word_ready_i     (word_ready_i),
        .half_pending_o   (half_pending_o),
        .compressed_cnt_o (compressed_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: RVC mapping built from field values with plain arithmetic.
    function automatic logic [16:0] ref_enc(input logic [31:0] i);
        int opc, rd, f3, rs1, rs2, f7, immi, imms, imm6;
        opc  = int'(i[6:0]);
        rd   = int'(i[11:7]);
        f3   = int'(i[14:12]);
        rs1  = int'(i[19:15]);
        rs2  = int'(i[24:20]);
        f7   = int'(i[31:25]);
        immi = int'($signed(i[31:20]));
        imms = int'($signed({i[31:25], i[11:7]}));
        imm6 = (immi & 31) * 4 + ((immi < 0) ? 4096 : 0);
        if (i[1:0] != 2'b11) return {1'b1, i[15:0]};
        if (i == 32'h0010_0073) return {1'b1, 16'h9002};
        if (opc == 'h67 && f3 == 0 && immi == 0 && rs1 != 0 && rd == 0)
            return {1'b1, 16'('h8002 + rs1 * 128)};
        if (opc == 'h67 && f3 == 0 && immi == 0 && rs1 != 0 && rd == 1)
            return {1'b1, 16'('h9002 + rs1 * 128)};
        if (opc == 'h33 && f3 == 0 && f7 == 0 && rd != 0 && rs2 != 0 && rs1 == 0)
            return {1'b1, 16'('h8002 + rd * 128 + rs2 * 4)};
        if (opc == 'h33 && f3 == 0 && f7 == 0 && rd != 0 && rs2 != 0 && rs1 == rd)
            return {1'b1, 16'('h9002 + rd * 128 + rs2 * 4)};
        if (opc == 'h13 && f3 == 0 && rd != 0 && immi >= -32 && immi <= 31 && rs1 == 0)
            return {1'b1, 16'('h4001 + rd * 128 + imm6)};
        if (opc == 'h13 && f3 == 0 && rd != 0 && immi >= -32 && immi <= 31 && rs1 == rd && immi != 0)
            return {1'b1, 16'('h0001 + rd * 128 + imm6)};
        if (opc == 'h13 && f3 == 1 && f7 == 0 && rd != 0 && rs1 == rd && rs2 > 0)
            return {1'b1, 16'('h0002 + rd * 128 + rs2 * 4)};
`ifdef IBEX_RVC_ENCODE_LOADSTORE_EN
        if (opc == 'h03 && f3 == 2 && rd >= 8 && rd <= 15 && rs1 >= 8 && rs1 <= 15 &&
            immi >= 0 && immi <= 124 && immi % 4 == 0)
            return {1'b1, 16'('h4000 + ((immi / 8) % 8) * 1024 + (rs1 - 8) * 128 +
                    ((immi / 4) % 2) * 64 + ((immi / 64) % 2) * 32 + (rd - 8) * 4)};
        if (opc == 'h23 && f3 == 2 && rs2 >= 8 && rs2 <= 15 && rs1 >= 8 && rs1 <= 15 &&
            imms >= 0 && imms <= 124 && imms % 4 == 0)
            return {1'b1, 16'('hC000 + ((imms / 8) % 8) * 1024 + (rs1 - 8) * 128 +
                    ((imms / 4) % 2) * 64 + ((imms / 64) % 2) * 32 + (rs2 - 8) * 4)};
`endif
        return {1'b0, 16'h0000};
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [4:0]  rd, rs1, rs2, lr1, lr2, lrd;
        logic [11:0] imm, off;
        rd  = 5'($urandom);
        rs2 = 5'($urandom);
        if ($urandom_range(0, 7) == 0) rd = 5'd0;
        case ($urandom_range(0, 2))
            0:       rs1 = 5'd0;
            1:       rs1 = rd;
            default: rs1 = 5'($urandom);
        endcase
        imm = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 80) - 40) : 12'($urandom);
        off = 12'($urandom_range(0, 33) * 4 + (($urandom_range(0, 5) == 0) ? 2 : 0));
        lr1 = ($urandom_range(0, 4) == 0) ? 5'($urandom) : {2'b01, 3'($urandom)};
        lr2 = ($urandom_range(0, 4) == 0) ? 5'($urandom) : {2'b01, 3'($urandom)};
        lrd = ($urandom_range(0, 4) == 0) ? 5'($urandom) : {2'b01, 3'($urandom)};
        case ($urandom_range(0, 9))
            0: return $urandom;
            1: return {16'($urandom), 14'($urandom), 2'($urandom_range(0, 2))};
            2: return 32'h0010_0073;
            3: return {(($urandom_range(0, 3) == 0) ? imm : 12'd0), rs1, 3'b000,
                       5'($urandom_range(0, 2)), 7'h67};
            4: return {(($urandom_range(0, 5) == 0) ? 7'h20 : 7'h00), rs2, rs1, 3'b000, rd, 7'h33};
            5: return {imm, rs1, 3'b000, rd, 7'h13};
            6: return {(($urandom_range(0, 5) == 0) ? 7'h20 : 7'h00), rs2, rs1, 3'b001, rd, 7'h13};
            7: return {off, lr1, 3'b010, lrd, 7'h03};
            8: return {off[11:5], lr2, lr1, 3'b010, off[4:0], 7'h23};
            default: return {20'($urandom), rd, 7'h37};
        endcase
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0; valid_i = 1'b0; flush_i = 1'b0; word_ready_i = 1'b1;
        repeat (3) step();
        n_tests++; if (word_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_word_valid got %0b want 0", word_valid_o); end
        n_tests++; if (word_o !== 32'h0) begin n_fail++; $display("FAIL reset_word got %h want 00000000", word_o); end
        n_tests++; if (half_pending_o !== 1'b0) begin n_fail++; $display("FAIL reset_half got %0b want 0", half_pending_o); end
        n_tests++; if (compressed_cnt_o !== 16'h0) begin n_fail++; $display("FAIL reset_cnt got %h want 0000", compressed_cnt_o); end
        n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", ready_o); end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_two_compressed();
        valid_i = 1'b1; instr_i = 32'h0010_8093;
        step();
        n_tests++; if (half_pending_o !== 1'b1) begin n_fail++; $display("FAIL two_c_half1 got %0b want 1", half_pending_o); end
        n_tests++; if (word_valid_o !== 1'b0) begin n_fail++; $display("FAIL two_c_nowd got %0b want 0", word_valid_o); end
        instr_i = 32'hFFF1_0113;
        step();
        valid_i = 1'b0;
        n_tests++; if (word_valid_o !== 1'b1 || word_o !== 32'h117D_0085) begin n_fail++; $display("FAIL two_c_word got %0b/%h want 1/117d0085", word_valid_o, word_o); end
        n_tests++; if (compressed_cnt_o !== 16'd2) begin n_fail++; $display("FAIL two_c_cnt got %0d want 2", compressed_cnt_o); end
        n_tests++; if (half_pending_o !== 1'b0) begin n_fail++; $display("FAIL two_c_half got %0b want 0", half_pending_o); end
        step();
        n_tests++; if (word_valid_o !== 1'b0) begin n_fail++; $display("FAIL two_c_drain got %0b want 0", word_valid_o); end
    endtask

    task automatic test_lui_empty();
        valid_i = 1'b1; instr_i = 32'h1234_50B7;
        step();
        valid_i = 1'b0;
        n_tests++; if (word_valid_o !== 1'b1 || word_o !== 32'h1234_50B7) begin n_fail++; $display("FAIL lui_word got %0b/%h want 1/123450b7", word_valid_o, word_o); end
        n_tests++; if (half_pending_o !== 1'b0) begin n_fail++; $display("FAIL lui_half got %0b want 0", half_pending_o); end
        step();
    endtask

    task automatic test_half_32();
        valid_i = 1'b1; instr_i = 32'h0010_8093;
        step();
        instr_i = 32'h1234_50B7;
        step();
        n_tests++; if (word_valid_o !== 1'b1 || word_o !== 32'h50B7_0085) begin n_fail++; $display("FAIL half32_word got %0b/%h want 1/50b70085", word_valid_o, word_o); end
        n_tests++; if (half_pending_o !== 1'b1) begin n_fail++; $display("FAIL half32_half got %0b want 1", half_pending_o); end
        instr_i = 32'h0010_0073;
        step();
        valid_i = 1'b0;
        n_tests++; if (word_valid_o !== 1'b1 || word_o !== 32'h9002_1234) begin n_fail++; $display("FAIL half32_ebreak got %0b/%h want 1/90021234", word_valid_o, word_o); end
        n_tests++; if (half_pending_o !== 1'b0) begin n_fail++; $display("FAIL half32_half2 got %0b want 0", half_pending_o); end
        n_tests++; if (compressed_cnt_o !== 16'd4) begin n_fail++; $display("FAIL half32_cnt got %0d want 4", compressed_cnt_o); end
        step();
    endtask

    task automatic test_flush();
        valid_i = 1'b1; instr_i = 32'h0010_8093;
        step();
        valid_i = 1'b0; flush_i = 1'b1;
        step();
        n_tests++; if (word_valid_o !== 1'b1 || word_o !== 32'h0001_0085) begin n_fail++; $display("FAIL flush_word got %0b/%h want 1/00010085", word_valid_o, word_o); end
        n_tests++; if (half_pending_o !== 1'b0) begin n_fail++; $display("FAIL flush_half got %0b want 0", half_pending_o); end
        step();
        n_tests++; if (word_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_again got %0b want 0", word_valid_o); end
        step();
        n_tests++; if (word_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_again2 got %0b want 0", word_valid_o); end
        flush_i = 1'b0;
    endtask

    task automatic test_backpressure();
        word_ready_i = 1'b0; valid_i = 1'b1; instr_i = 32'h1234_50B7;
        step();
        instr_i = 32'h0010_8093;
        #1;
        n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready0 got %0b want 0", ready_o); end
        for (int k = 0; k < 5; k++) begin
            step();
            n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_hold got %0b want 0", ready_o); end
            n_tests++; if (word_valid_o !== 1'b1 || word_o !== 32'h1234_50B7) begin n_fail++; $display("FAIL bp_stable got %0b/%h want 1/123450b7", word_valid_o, word_o); end
            n_tests++; if (half_pending_o !== 1'b0) begin n_fail++; $display("FAIL bp_no_accept got %0b want 0", half_pending_o); end
        end
        word_ready_i = 1'b1;
        #1;
        n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_release got %0b want 1", ready_o); end
        step();
        valid_i = 1'b0;
        n_tests++; if (half_pending_o !== 1'b1 || word_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_xfer got half %0b wv %0b want 1 0", half_pending_o, word_valid_o); end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        n_tests++; if (word_valid_o !== 1'b1 || word_o !== 32'h0001_0085) begin n_fail++; $display("FAIL bp_flush got %0b/%h want 1/00010085", word_valid_o, word_o); end
        n_tests++; if (compressed_cnt_o !== 16'd6) begin n_fail++; $display("FAIL bp_cnt got %0d want 6", compressed_cnt_o); end
        step();
    endtask

    task automatic test_loadstore();
        valid_i = 1'b1; instr_i = 32'h0044_A403;
        step();
        valid_i = 1'b0;
`ifdef IBEX_RVC_ENCODE_LOADSTORE_EN
        n_tests++; if (half_pending_o !== 1'b1 || word_valid_o !== 1'b0) begin n_fail++; $display("FAIL lw_comp got half %0b wv %0b want 1 0", half_pending_o, word_valid_o); end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        n_tests++; if (word_valid_o !== 1'b1 || word_o !== 32'h0001_40C0) begin n_fail++; $display("FAIL lw_word got %0b/%h want 1/000140c0", word_valid_o, word_o); end
`else
        n_tests++; if (word_valid_o !== 1'b1 || word_o !== 32'h0044_A403) begin n_fail++; $display("FAIL lw_word got %0b/%h want 1/0044a403", word_valid_o, word_o); end
        n_tests++; if (half_pending_o !== 1'b0) begin n_fail++; $display("FAIL lw_half got %0b want 0", half_pending_o); end
`endif
        step();
    endtask

    task automatic test_reset_mid();
        word_ready_i = 1'b1; valid_i = 1'b1; instr_i = 32'h0010_8093;
        step();
        word_ready_i = 1'b0; instr_i = 32'h1234_50B7;
        step();
        valid_i = 1'b0;
        n_tests++; if (word_valid_o !== 1'b1 || half_pending_o !== 1'b1) begin n_fail++; $display("FAIL rmid_setup got wv %0b half %0b want 1 1", word_valid_o, half_pending_o); end
        #2 rst_ni = 1'b0;
        #1;
        n_tests++; if (word_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_wv got %0b want 0", word_valid_o); end
        n_tests++; if (compressed_cnt_o !== 16'h0) begin n_fail++; $display("FAIL rmid_cnt got %0d want 0", compressed_cnt_o); end
        n_tests++; if (half_pending_o !== 1'b0 || word_o !== 32'h0) begin n_fail++; $display("FAIL rmid_state got half %0b word %h want 0 0", half_pending_o, word_o); end
        step();
        rst_ni = 1'b1; word_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++; if (word_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_quiet got %0b want 0", word_valid_o); end
        end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        n_tests++; if (word_valid_o !== 1'b0 || half_pending_o !== 1'b0) begin n_fail++; $display("FAIL rmid_nopad got wv %0b half %0b want 0 0", word_valid_o, half_pending_o); end
    endtask

    // Model: encoder output is a stream of halfwords; every two form one word.
    task automatic test_random();
        logic [15:0] halfq[$];
        logic [31:0] expw[$];
        logic [15:0] mcnt;
        logic [16:0] r;
        logic        mready;
        mcnt = 16'h0;
        for (int k = 0; k < 3000; k++) begin
            valid_i      = ($urandom_range(0, 2) != 0);
            instr_i      = gen_instr();
            flush_i      = ($urandom_range(0, 3) == 0);
            word_ready_i = ($urandom_range(0, 3) != 0);
            #1;
            mready = (expw.size() == 0) || word_ready_i;
            n_tests++; if (ready_o !== mready) begin n_fail++; $display("FAIL rnd_ready cyc %0d got %0b want %0b", k, ready_o, mready); end
            n_tests++; if (word_valid_o !== (expw.size() != 0)) begin n_fail++; $display("FAIL rnd_wv cyc %0d got %0b want %0b", k, word_valid_o, expw.size() != 0); end
            n_tests++; if (half_pending_o !== (halfq.size() == 1)) begin n_fail++; $display("FAIL rnd_half cyc %0d got %0b want %0b", k, half_pending_o, halfq.size() == 1); end
            n_tests++; if (compressed_cnt_o !== mcnt) begin n_fail++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", k, compressed_cnt_o, mcnt); end
            if (expw.size() != 0 && word_ready_i) begin
                n_tests++; if (word_o !== expw[0]) begin n_fail++; $display("FAIL rnd_word cyc %0d got %h want %h", k, word_o, expw[0]); end
                void'(expw.pop_front());
            end
            if (valid_i && mready) begin
                r = ref_enc(instr_i);
                if (r[16]) begin
                    halfq.push_back(r[15:0]);
                    if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
                end else begin
                    halfq.push_back(instr_i[15:0]);
                    halfq.push_back(instr_i[31:16]);
                end
            end else if (flush_i && mready && halfq.size() == 1) begin
                halfq.push_back(16'h0001);
            end
            if (halfq.size() >= 2) begin
                expw.push_back({halfq[1], halfq[0]});
                void'(halfq.pop_front());
                void'(halfq.pop_front());
            end
            step();
        end
        valid_i = 1'b0; flush_i = 1'b0; word_ready_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_two_compressed();
        test_lui_empty();
        test_half_32();
        test_flush();
        test_backpressure();
        test_loadstore();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_compressed_encoder.md
IBEX_COMPRESSED_ENCODER -- requirements
Module: ibex_compressed_encoder

Interface
REQ-001 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port valid_i  input  1  input instruction valid.
REQ-004 SHALL have port instr_i  input  32  RV32I instruction to encode.
REQ-005 SHALL have port ready_o  output  1  encoder accepts instr_i this cycle.
REQ-006 SHALL have port flush_i  input  1  pad and emit any pending halfword.
REQ-007 SHALL have port word_valid_o  output  1  packed output word valid.
REQ-008 SHALL have port word_o  output  32  packed word; bits [15:0] are the older halfword.
REQ-009 SHALL have port word_ready_i  input  1  downstream accepts word_o.
REQ-010 SHALL have port half_pending_o  output  1  one halfword held in the pack register.
REQ-011 SHALL have port compressed_cnt_o  output  16  count of instructions emitted in 16-bit form, saturating.

Function
REQ-012 SHALL drive ready_o = !word_valid_o || word_ready_i; a transfer occurs when valid_i && ready_o.
REQ-013 SHALL map accepted instructions combinationally to one 16-bit form, first match wins: ebreak -> 0x9002; jalr x0,0(rs1), rs1!=0 -> c.jr; jalr x1,0(rs1), rs1!=0 -> c.jalr; add rd,x0,rs2, rd!=0, rs2!=0 -> c.mv; add rd,rd,rs2, rd!=0, rs2!=0 -> c.add; addi rd,x0,imm, rd!=0, imm in [-32,31] -> c.li; addi rd,rd,imm, rd!=0, imm!=0, imm in [-32,31] -> c.addi; slli rd,rd,sh, rd!=0, 0<sh<32 -> c.slli; c.lw/c.sw per REQ-025.
REQ-014 SHALL use only the standard RVC bit layouts, so that ibex_compressed_decoder reproduces the original instruction exactly.
REQ-015 SHALL treat instr_i[1:0]!=2'b11 as an already-compressed halfword: pack instr_i[15:0] unchanged and count it as compressed.
REQ-016 SHALL keep all other instructions 32-bit and pass them unchanged.
REQ-017 SHALL implement a 2-state packer, EMPTY and HALF, with a 16-bit pending register:
- EMPTY + 16-bit form -> pending=c, go to HALF, no word.
- EMPTY + 32-bit form -> word=instr, stay in EMPTY.
- HALF + 16-bit form -> word={c,pending}, go to EMPTY.
- HALF + 32-bit form -> word={instr[15:0],pending}, pending=instr[31:16], stay in HALF.
REQ-018 SHALL register word_o/word_valid_o with one-cycle latency from the transfer, and hold word_o stable while word_valid_o && !word_ready_i.
REQ-019 SHALL act on flush_i only when valid_i=0 and ready_o=1:
- HALF -> word={16'h0001,pending} (c.nop pad), go to EMPTY.
- EMPTY -> no effect.
REQ-020 SHALL give valid_i priority over flush_i in the same cycle; flush_i is then ignored.
REQ-021 SHALL increment compressed_cnt_o once per 16-bit form accepted (including REQ-015), and saturate at 0xFFFF.
REQ-022 SHALL drive half_pending_o=1 exactly in state HALF.

Reset
REQ-023 SHALL, while rst_ni=0, force state EMPTY, pending=0, word_valid_o=0, word_o=0, compressed_cnt_o=0.
REQ-024 SHALL discard any pending halfword and unaccepted word on reset mid-operation; nothing is emitted after reset release until new input arrives.

Configuration
REQ-025 SHALL, with IBEX_RVC_ENCODE_LOADSTORE_EN defined, encode c.lw/c.sw for lw/sw whose rd/rs1/rs2 are all in x8..x15 and whose offset is a multiple of 4 in [0,124].
REQ-026 SHALL, without IBEX_RVC_ENCODE_LOADSTORE_EN defined, emit all loads and stores in 32-bit form.

Structure
REQ-027 SHALL place the packer state enum, the opcode constants and the 0x0001/0x9002 constants in ibex_pkg.
REQ-028 SHALL implement the instruction mapping as a purely combinational sub-module ibex_compressed_encode_lut (instr in; 16-bit form plus is_comp out); packing, handshake and counter live in the top module.

Verification
REQ-029 SHALL cover: reset, then 0x00108093 followed by 0xFFF10113 -> one word 0x117D0085, compressed_cnt_o=2, half_pending_o=0.
REQ-030 SHALL cover: EMPTY, 0x123450B7 (lui) -> word 0x123450B7 one cycle later, state stays EMPTY.
REQ-031 SHALL cover: HALF with pending 0x0085, then 0x123450B7 -> word 0x50B70085, pending 0x1234, half_pending_o=1; then 0x00100073 -> word 0x90021234.
REQ-032 SHALL cover: HALF with pending 0x0085, flush_i=1, valid_i=0 -> word 0x00010085, state EMPTY; flush_i again -> no word.
REQ-033 SHALL cover: word_ready_i=0 with word_valid_o=1 -> ready_o=0, word_o stable for 5 cycles; releasing word_ready_i -> transfer and ready_o=1.
REQ-034 SHALL cover: 0x0044A403 -> 16-bit form 0x40C0 with the macro defined, 32-bit 0x0044A403 without it; rst_ni pulse in HALF -> word_valid_o=0, compressed_cnt_o=0, no pad word emitted.
